// File: rtl/led_pkg.sv
// Shared types and helpers for the LED frame controller: FSM states, pixel
// widths and the per-byte brightness scaling used in the capture path.
package led_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FETCH    = 3'd1,
      WAIT     = 3'd2,
      SEND_BIT = 3'd3,
      SEND_RST = 3'd4
   } state_t;

   localparam int BPP_RGB  = 24;
   localparam int BPP_RGBW = 32;

   // bright+1 makes 255 an exact identity and 0 a hard blank.
   function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] bright);
      logic [15:0] prod;
      prod = {8'd0, c} * ({8'd0, bright} + 16'd1);
      return prod[15:8];
   endfunction

endpackage

// File: rtl/led_frame_ctl_if.sv
// Controller-side buses: synchronous pixel RAM read port and bit handoff to
// the downstream timing encoder.
interface led_frame_ctl_if #(
   parameter int BPP    = 24,
   parameter int ADDR_W = 6
);
   // RAM: rd_data is valid exactly one cycle after rd_en. Encoder: bit_rdy is a
   // one-cycle pulse offering bit_data (held until the next bit_rdy); the bit is
   // outstanding until the encoder pulses bit_done, and only then is another
   // bit offered. bit_done with nothing outstanding is ignored.
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [BPP-1:0]    rd_data;
   logic              bit_rdy;
   logic              bit_data;
   logic              bit_done;

   modport master (
      output rd_en, rd_addr, bit_rdy, bit_data,
      input  rd_data, bit_done
   );

   modport slave (
      input  rd_en, rd_addr, bit_rdy, bit_data,
      output rd_data, bit_done
   );
endinterface

// File: rtl/led_px_scaler.sv
// Combinational per-byte brightness scaler for one BPP-wide pixel word.
module led_px_scaler
   import led_pkg::*;
#(
   parameter int BPP = BPP_RGB
) (
   input  logic [BPP-1:0] px,
   input  logic [7:0]     bright,
   output logic [BPP-1:0] px_scaled
);

   for (genvar i = 0; i < BPP / 8; i++) begin : g_byte
      assign px_scaled[i*8 +: 8] = scale8(px[i*8 +: 8], bright);
   end

endmodule

// File: rtl/led_frame_ctl.sv
// Frame controller: fetches pixels from RAM, scales them, shifts them MSB
// first to the bit encoder, then holds the latch (reset) code.
module led_frame_ctl
   import led_pkg::*;
#(
   parameter int BPP    = BPP_RGB,
   parameter int ADDR_W = 6,
   parameter int CNT_W  = 7,
   parameter int RST_W  = 16
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              start_in,
   input  logic              auto_in,
   input  logic              stop_in,
   input  logic [ADDR_W-1:0] start_addr_in,
   input  logic [CNT_W-1:0]  pix_cnt_in,
   input  logic [7:0]        bright_in,
   input  logic [RST_W-1:0]  rst_cnt_in,
   output logic              busy_out,
   output logic              frame_done_out,
   output state_t            dbg_state,
   led_frame_ctl_if.master   bus
);

   localparam int IDX_W = $clog2(BPP);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [7:0]        bright_q;
   logic [RST_W-1:0]  rst_len_q;
   logic [RST_W-1:0]  rst_ctr_q;
   logic              auto_q;
   logic [BPP-1:0]    shreg_q;
   logic [IDX_W-1:0]  bit_idx_q;
   logic              out_q;

   logic [BPP-1:0]    px_scaled;
   logic [RST_W-1:0]  rst_eff;
   logic              rst_last;
   logic              bit_counted;
   logic              last_bit;
   logic              restart;
   logic              relatch;

   led_px_scaler #(.BPP(BPP)) u_scaler (
      .px        (bus.rd_data),
      .bright    (bright_q),
      .px_scaled (px_scaled)
   );

   assign rst_eff     = (rst_len_q == '0) ? RST_W'(1) : rst_len_q;
   assign rst_last    = (state == SEND_RST) && (rst_ctr_q == rst_eff - RST_W'(1));
   assign bit_counted = (state == SEND_BIT) && out_q && bus.bit_done;
   assign last_bit    = (bit_idx_q == IDX_W'(BPP - 1));
   // A stop arriving in the very last latch cycle still cancels the restart.
   assign restart     = rst_last && auto_q && !stop_in;
   assign relatch     = ((state == IDLE) && start_in) || restart;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) state <= IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (start_in) state_nxt = (pix_cnt_in == '0) ? SEND_RST : FETCH;
         FETCH:    state_nxt = WAIT;
         WAIT:     state_nxt = SEND_BIT;
         SEND_BIT: if (bit_counted && last_bit)
                      state_nxt = (cnt_q == CNT_W'(1)) ? SEND_RST : FETCH;
         SEND_RST: if (rst_last) begin
                      if (restart) state_nxt = (pix_cnt_in == '0) ? SEND_RST : FETCH;
                      else         state_nxt = IDLE;
                   end
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.rd_en      = 1'b0;
      bus.rd_addr    = '0;
      bus.bit_rdy    = 1'b0;
      bus.bit_data   = shreg_q[BPP-1];
      busy_out       = (state != IDLE);
      frame_done_out = rst_last;
      dbg_state      = state;
      if (state == FETCH) begin
         bus.rd_en   = 1'b1;
         bus.rd_addr = addr_q;
      end
      if ((state == SEND_BIT) && !out_q) bus.bit_rdy = 1'b1;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         addr_q    <= '0;
         cnt_q     <= '0;
         bright_q  <= '0;
         rst_len_q <= '0;
         rst_ctr_q <= '0;
         auto_q    <= 1'b0;
         shreg_q   <= '0;
         bit_idx_q <= '0;
         out_q     <= 1'b0;
      end else begin
         if (stop_in) auto_q <= 1'b0;
         case (state)
            WAIT: begin
               shreg_q   <= px_scaled;
               bit_idx_q <= '0;
               out_q     <= 1'b0;
            end
            SEND_BIT: begin
               if (!out_q) begin
                  out_q <= 1'b1;
               end else if (bus.bit_done) begin
                  out_q <= 1'b0;
                  // The final bit is not shifted out so bit_data holds until the next pixel loads.
                  if (last_bit) begin
                     bit_idx_q <= '0;
                     cnt_q     <= cnt_q - CNT_W'(1);
                     addr_q    <= addr_q + ADDR_W'(1);
                  end else begin
                     bit_idx_q <= bit_idx_q + IDX_W'(1);
                     shreg_q   <= shreg_q << 1;
                  end
               end
            end
            SEND_RST: rst_ctr_q <= rst_last ? '0 : rst_ctr_q + RST_W'(1);
            default: ;
         endcase
         if (relatch) begin
            addr_q    <= start_addr_in;
            cnt_q     <= pix_cnt_in;
            bright_q  <= bright_in;
            rst_len_q <= rst_cnt_in;
            auto_q    <= auto_in && !stop_in;
            rst_ctr_q <= '0;
         end
      end
   end

endmodule

// File: tb/tb_led_frame_ctl.sv
// Bench for led_frame_ctl: RAM and encoder models, a frame-level reference
// model feeding expected queues, and a monitor that checks every DUT output event.
module tb_led_frame_ctl;
   import led_pkg::*;

   localparam int BPP    = BPP_RGB;
   localparam int B32    = BPP_RGBW;
   localparam int ADDR_W = 6;
   localparam int CNT_W  = 7;
   localparam int RST_W  = 16;
   localparam int DEPTH  = 1 << ADDR_W;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // main DUT (RGB)
   logic              start_s = 0, auto_s = 0, stop_s = 0;
   logic [ADDR_W-1:0] sa_s = '0;
   logic [CNT_W-1:0]  cnt_s = '0;
   logic [7:0]        bright_s = '0;
   logic [RST_W-1:0]  rstc_s = '0;
   logic              busy, frame_done;
   state_t            dbg_state;
   led_frame_ctl_if #(.BPP(BPP), .ADDR_W(ADDR_W)) bus();

   led_frame_ctl #(.BPP(BPP), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .RST_W(RST_W)) u_dut (
      .clk_in(clk), .rst_n_in(rst_n), .start_in(start_s), .auto_in(auto_s), .stop_in(stop_s),
      .start_addr_in(sa_s), .pix_cnt_in(cnt_s), .bright_in(bright_s), .rst_cnt_in(rstc_s),
      .busy_out(busy), .frame_done_out(frame_done), .dbg_state(dbg_state), .bus(bus)
   );

   // second DUT (RGBW)
   logic   start32 = 0;
   logic   busy32, frame_done32;
   state_t dbg_state32;
   led_frame_ctl_if #(.BPP(B32), .ADDR_W(ADDR_W)) bus32();

   led_frame_ctl #(.BPP(B32), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .RST_W(RST_W)) u_dut32 (
      .clk_in(clk), .rst_n_in(rst_n), .start_in(start32), .auto_in(1'b0), .stop_in(1'b0),
      .start_addr_in(ADDR_W'(0)), .pix_cnt_in(CNT_W'(1)), .bright_in(8'd255), .rst_cnt_in(RST_W'(2)),
      .busy_out(busy32), .frame_done_out(frame_done32), .dbg_state(dbg_state32), .bus(bus32)
   );

   // scoreboard state
   logic [0:0]        exp_bit_q[$];
   logic [ADDR_W-1:0] exp_addr_q[$];
   logic [RST_W-1:0]  exp_rst_q[$];
   int vectors = 0, miscompares = 0;
   int start_cyc = 0, last_done_cyc = 0, last_fd_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // reference model
   logic [BPP-1:0] ram[DEPTH];

   function automatic logic [7:0] ref_scale(input logic [7:0] c, input logic [7:0] b);
      return 8'((int'(c) * (int'(b) + 1)) / 256);
   endfunction

   task automatic push_frame(input int a, input int n, input int b, input int r);
      logic [ADDR_W-1:0] ad;
      logic [BPP-1:0]    px, sc;
      for (int i = 0; i < n; i++) begin
         ad = ADDR_W'((a + i) % DEPTH);
         exp_addr_q.push_back(ad);
         px = ram[ad];
         for (int k = 0; k < BPP / 8; k++) sc[8*k +: 8] = ref_scale(px[8*k +: 8], 8'(b));
         for (int j = BPP - 1; j >= 0; j--) exp_bit_q.push_back(sc[j]);
      end
      exp_rst_q.push_back(RST_W'((r == 0) ? 1 : r));
   endtask

   // RAM model: data valid only in the cycle after rd_en
   logic              rd_pend = 0;
   logic [ADDR_W-1:0] rd_pend_addr = '0;
   initial begin
      bus.rd_data = '0;
      forever begin
         @(negedge clk);
         bus.rd_data  = rd_pend ? ram[rd_pend_addr] : BPP'($urandom);
         rd_pend      = bus.rd_en;
         rd_pend_addr = bus.rd_addr;
      end
   end

   // encoder model with random latency and optional spurious bit_done
   int enc_cnt = 0, lat_min = 3, lat_max = 3;
   bit spur_en = 0;
   initial begin
      bus.bit_done = 1'b0;
      forever begin
         @(negedge clk);
         bus.bit_done = 1'b0;
         if (!rst_n) begin
            enc_cnt = 0;
         end else begin
            if (enc_cnt > 0) begin
               enc_cnt--;
               if (enc_cnt == 0) begin
                  bus.bit_done  = 1'b1;
                  last_done_cyc = cyc;
               end
            end else if (spur_en && ($urandom_range(0, 3) == 0)) begin
               bus.bit_done = 1'b1;
            end
            if (bus.bit_rdy) enc_cnt = $urandom_range(lat_min, lat_max);
         end
      end
   end

   // RGBW side models
   logic           rd_pend32 = 0, rdy_pend32 = 0;
   logic [B32-1:0] cap32 = '0;
   int             nbits32 = 0;
   initial begin
      bus32.rd_data  = '0;
      bus32.bit_done = 1'b0;
      forever begin
         @(negedge clk);
         bus32.rd_data  = rd_pend32 ? 32'h0102_0304 : $urandom;
         rd_pend32      = bus32.rd_en;
         bus32.bit_done = rdy_pend32;
         rdy_pend32     = bus32.bit_rdy;
         if (bus32.bit_rdy) begin
            cap32 = {cap32[B32-2:0], bus32.bit_data};
            nbits32++;
         end
      end
   end

   // monitor
   initial begin
      logic [0:0] eb;
      int anchor;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.bit_rdy) begin
               if (exp_bit_q.size() == 0) check("unexpected_bit_rdy", 1, 0);
               else begin
                  eb = exp_bit_q.pop_front();
                  check("bit_data", 32'(bus.bit_data), 32'(eb));
               end
            end
            if (bus.rd_en) begin
               if (exp_addr_q.size() == 0) check("unexpected_rd_en", 1, 0);
               else check("rd_addr", 32'(bus.rd_addr), 32'(exp_addr_q.pop_front()));
            end
            if (frame_done) begin
               anchor = start_cyc;
               if (last_done_cyc > anchor) anchor = last_done_cyc;
               if (last_fd_cyc > anchor) anchor = last_fd_cyc;
               if (exp_rst_q.size() == 0) check("unexpected_frame_done", 1, 0);
               else check("reset_code_len", 32'(cyc - anchor), 32'(exp_rst_q.pop_front()));
               last_fd_cyc = cyc;
            end
            if (bus32.rd_en) check("rd_addr32", 32'(bus32.rd_addr), 0);
         end
      end
   end

   // driver tasks
   task automatic set_ports(input int a, input int n, input int b, input int r, input bit au);
      sa_s = ADDR_W'(a); cnt_s = CNT_W'(n); bright_s = 8'(b); rstc_s = RST_W'(r); auto_s = au;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start_s = 1'b1;
      if (!busy) start_cyc = cyc;
      @(negedge clk);
      start_s = 1'b0;
   endtask

   task automatic wait_frame_done(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_done && n < 3000);
      if (!frame_done) check({name, "_timeout"}, 0, 1);
   endtask

   task automatic post_frame(input string name);
      @(negedge clk);
      check({name, "_queues_empty"}, 32'(exp_bit_q.size() + exp_addr_q.size() + exp_rst_q.size()), 0);
      check({name, "_idle"}, {31'd0, busy}, 0);
   endtask

   task automatic run_frame(input string name, input int a, input int n, input int b, input int r);
      set_ports(a, n, b, r, 0);
      push_frame(a, n, b, r);
      pulse_start();
      wait_frame_done(name);
      post_frame(name);
   endtask

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, rdy_seen, a, c, b, r;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_outputs", {26'd0, frame_done, bus.rd_en, bus.bit_rdy, bus.bit_data, busy32, frame_done32}, 0);
      check("rst_rd_addr", 32'(bus.rd_addr), 0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // two full-intensity pixels, fixed encoder latency of 3
      ram[0] = 24'hFF0000; ram[1] = 24'h00FF01;
      run_frame("two_px", 0, 2, 255, 4);

      // brightness scaling: half and zero
      ram[10] = 24'h80FF02;
      run_frame("bright127", 10, 1, 127, 2);
      run_frame("bright0", 10, 1, 0, 1);

      // address wrap with random latency
      lat_min = 1; lat_max = 4;
      for (int i = 0; i < DEPTH; i++) ram[i] = BPP'($urandom);
      run_frame("wrap", DEPTH - 1, 3, 200, 3);

      // empty frame: reset code only
      set_ports(7, 0, 255, 5, 0);
      push_frame(7, 0, 255, 5);
      pulse_start();
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("empty_busy_cycles", 32'(n), 5);
      check("empty_queues_empty", 32'(exp_bit_q.size() + exp_addr_q.size() + exp_rst_q.size()), 0);

      // auto-refresh: new brightness per frame, stop ends after the current frame
      set_ports(5, 1, 255, 3, 1);
      push_frame(5, 1, 255, 3);
      pulse_start();
      bright_s = 8'd100;
      push_frame(5, 1, 100, 3);
      wait_frame_done("auto1");
      @(negedge clk);
      bright_s = 8'd50;
      push_frame(5, 1, 50, 3);
      wait_frame_done("auto2");
      repeat (10) @(negedge clk);
      stop_s = 1'b1;
      @(negedge clk);
      stop_s = 1'b0;
      wait_frame_done("auto3");
      post_frame("auto_stop");
      repeat (30) @(negedge clk);
      check("auto_stays_idle", {31'd0, busy}, 0);
      auto_s = 1'b0;

      // random frames with spurious bit_done and start while busy
      spur_en = 1;
      for (int f = 0; f < 8; f++) begin
         for (int i = 0; i < DEPTH; i++) ram[i] = BPP'($urandom);
         a = $urandom_range(0, DEPTH - 1);
         c = $urandom_range(0, 4);
         case ($urandom_range(0, 2))
            0: b = 0;
            1: b = 255;
            default: b = $urandom_range(0, 255);
         endcase
         r = $urandom_range(0, 6);
         set_ports(a, c, b, r, 0);
         push_frame(a, c, b, r);
         pulse_start();
         @(negedge clk);
         if (busy) begin
            set_ports($urandom_range(0, DEPTH - 1), $urandom_range(1, 4), $urandom_range(0, 255), 9, 1);
            start_s = 1'b1;
            @(negedge clk);
            start_s = 1'b0;
            auto_s  = 1'b0;
         end
         wait_frame_done("rand");
         post_frame("rand");
      end
      spur_en = 0;

      // asynchronous reset in the middle of a pixel
      ram[0] = 24'hA5A5A5;
      set_ports(0, 2, 255, 4, 0);
      push_frame(0, 2, 255, 4);
      pulse_start();
      repeat (30) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_state", 32'(dbg_state), 32'(IDLE));
      check("midrst_outputs", {27'd0, busy, frame_done, bus.rd_en, bus.bit_rdy, bus.bit_data}, 0);
      exp_bit_q.delete(); exp_addr_q.delete(); exp_rst_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rdy_seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.bit_rdy || busy) rdy_seen++;
      end
      check("post_rst_quiet", 32'(rdy_seen), 0);

      // RGBW pixel on the 32-bit instance
      cap32 = '0; nbits32 = 0;
      @(negedge clk);
      start32 = 1'b1;
      @(negedge clk);
      start32 = 1'b0;
      n = 0;
      while (!frame_done32 && n < 1000) begin
         n++;
         @(negedge clk);
      end
      check("rgbw_frame_done", {31'd0, frame_done32}, 1);
      check("rgbw_bits", cap32, 32'h0102_0304);
      check("rgbw_bit_count", 32'(nbits32), 32);
      repeat (3) @(negedge clk);
      check("rgbw_idle", {31'd0, busy32}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/led_frame_ctl.md
Name: led_frame_ctl

Overview:
Parametrised successor to the single-string WS2812 frame controller. Streams a frame of pixels (24-bit RGB or 32-bit RGBW) from an external synchronous pixel RAM to the downstream bit encoder, MSB first. Applies per-frame global brightness scaling, then emits the reset (latch) code. Supports single-shot and auto-refresh modes. Sits between the host-side RAM writer and the bit-timing encoder.

Parameters:
BPP, 24, bits per pixel; 24 or 32 only, must be a multiple of 8.
ADDR_W, 6, pixel RAM address width; addresses wrap modulo 2^ADDR_W.
CNT_W, 7, width of pixel count input; max frame is 2^CNT_W-1 pixels.
RST_W, 16, width of reset-code length input, in clk_in cycles.

Ports:
clk_in  in  1  clock
rst_n_in  in  1  reset, asynchronous, active-low
start_in  in  1  single-cycle frame request; sampled only in IDLE
auto_in  in  1  auto-refresh mode, latched with start_in
stop_in  in  1  clears latched auto mode; the current frame still completes
start_addr_in  in  ADDR_W  address of first pixel
pix_cnt_in  in  CNT_W  number of pixels in the frame
bright_in  in  8  global brightness; 255 = unscaled
rst_cnt_in  in  RST_W  reset-code length in cycles; 0 is treated as 1
rd_en_out  out  1  RAM read strobe
rd_addr_out  out  ADDR_W  RAM read address
rd_data_in  in  BPP  RAM data; valid exactly 1 cycle after rd_en_out
bit_done_in  in  1  encoder finished the outstanding bit
bit_rdy_out  out  1  single-cycle pulse presenting a new bit
bit_data_out  out  1  bit value; held until the next bit_rdy_out
busy_out  out  1  high in any state other than IDLE
frame_done_out  out  1  single-cycle pulse at the end of the reset code

Behaviour:
- Reset: state=IDLE. All outputs are 0, and all internal registers and counters are 0.
- States: IDLE, FETCH, WAIT, SEND_BIT, SEND_RST.
- IDLE + start_in:
  - Latch start_addr_in, pix_cnt_in, bright_in, auto_in and rst_cnt_in.
  - If pix_cnt_in==0, go to SEND_RST; otherwise go to FETCH.
- FETCH (1 cycle): rd_en_out=1, rd_addr_out=current address. Next state is WAIT.
- WAIT (1 cycle): capture rd_data_in, scaled per byte, into a BPP-bit shift register, then go to SEND_BIT.
- Scaling: each byte c becomes ((c*(bright+1))>>8)[7:0]. bright=255 gives identity; bright=0 gives 0.
- SEND_BIT:
  - On the first cycle after WAIT, drive bit_rdy_out=1 with the shift register MSB, and set the outstanding flag.
  - bit_done_in counts only while the flag is set. Each counted bit_done_in clears the flag and advances the bit index.
  - If bits remain, bit_rdy_out pulses on the next cycle with the next bit.
  - After the BPP-th counted bit_done_in, decrement the pixel count and increment the address (with wrap).
  - Then go to FETCH if pixels remain, else to SEND_RST.
- bit_done_in is ignored in every state other than SEND_BIT, and whenever no bit is outstanding.
- Inter-bit gap: 1 cycle within a pixel. Between pixels, the gap is 3 cycles (FETCH, WAIT, first SEND_BIT cycle).
- SEND_RST:
  - Stay max(rst_cnt,1) cycles; no bit_rdy_out in this state.
  - On the last cycle, pulse frame_done_out.
  - Then: if auto is latched and no stop_in has been seen since start, re-latch all inputs from the ports and restart (FETCH, or SEND_RST if the count is 0). Otherwise go to IDLE.
- stop_in at any time clears the latched auto bit; it never aborts a frame.
- start_in while busy is ignored.
- busy_out is combinational from the state register.
- Reset mid-frame: immediate return to IDLE. No partial bit pulse may occur after rst_n_in deasserts.

Decomposition:
- Package led_pkg:
  - state enum typedef (IDLE, FETCH, WAIT, SEND_BIT, SEND_RST)
  - BPP_RGB=24, BPP_RGBW=32
  - function scale8(c, bright)
- One sub-module, led_px_scaler: combinational BPP-wide per-byte scaler, instantiated once in the capture path.

Test Plan:
- BPP=24, start_addr=0, cnt=2, bright=255, RAM[0]=0xFF0000, RAM[1]=0x00FF01, encoder returns bit_done_in 3 cycles after each rdy -> 48 bits in order FF0000 then 00FF01. rd_addr_out sequence is 0 then 1. frame_done_out pulses once after rst_cnt cycles.
- bright=127, pixel 0x80FF02 -> emitted bits 0x407F01. bright=0 -> 24 zero bits.
- start_addr=2^ADDR_W-1, cnt=3 -> rd_addr_out sequence is 63, 0, 1 (wrap).
- cnt=0, rst_cnt=5 -> no bit_rdy_out, busy_out high 5 cycles, frame_done_out pulses once, then IDLE.
- auto_in=1, cnt=1 -> repeated frames with new bright_in picked up at the next frame. stop_in mid-frame -> that frame completes, then IDLE.
- BPP=32 build, pixel 0x01020304 -> 32 bits MSB first. Spurious bit_done_in in IDLE/SEND_RST and start_in while busy -> no effect. rst_n_in low mid-pixel -> outputs 0 and state IDLE.
